// File: rtl/v_instr_dispatcher.sv
// Vector instruction dispatcher: operand FIFO toward the vector core,
// outstanding load/store tracking for fences, and scalar-side stall.
module v_instr_dispatcher #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] v_instr_i,
    input  logic        v_instr_valid_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        vector_stall_o,
    output logic [31:0] vector_instr_o,
    output logic [31:0] rs1_o,
    output logic [31:0] rs2_o,
    output logic        v_valid_o,
    input  logic        v_ready_i,
    input  logic        v_load_done_i,
    input  logic        v_store_done_i,
    output logic        all_v_loads_executed_o,
    output logic        all_v_stores_executed_o,
    output logic        underflow_err_o
);

    localparam int IW = $clog2(FIFO_DEPTH);
    localparam int PW = IW + 1;
    localparam logic [6:0] OPC_LOAD  = 7'b0000111;
    localparam logic [6:0] OPC_STORE = 7'b0100111;
    localparam logic [6:0] OPC_OPV   = 7'b1010111;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
    logic [CNT_W-1:0] st_cnt_q, st_cnt_d;
    logic             err_q, err_d;

    logic [31:0] instr_mem_q [FIFO_DEPTH];
    logic [31:0] rs1_mem_q   [FIFO_DEPTH];
    logic [31:0] rs2_mem_q   [FIFO_DEPTH];

    logic is_load, is_store, is_opv, is_legal;
    logic empty, full, push, pop;
    logic ld_inc, st_inc;
    logic [IW-1:0] wr_idx, rd_idx;

    assign is_load  = (v_instr_i[6:0] == OPC_LOAD);
    assign is_store = (v_instr_i[6:0] == OPC_STORE);
    assign is_opv   = (v_instr_i[6:0] == OPC_OPV);
    assign is_legal = is_load | is_store | is_opv;

    assign wr_idx = wr_ptr_q[IW-1:0];
    assign rd_idx = rd_ptr_q[IW-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[IW] != rd_ptr_q[IW]);

    // No pop-to-push bypass: full is judged on registered pointers only.
    assign vector_stall_o = v_instr_valid_i &
                            (full |
                             (is_load & (ld_cnt_q == CNT_MAX)) |
                             (is_store & (st_cnt_q == CNT_MAX)));

    assign push   = v_instr_valid_i & ~vector_stall_o & is_legal;
    assign pop    = v_valid_o & v_ready_i;
    assign ld_inc = push & is_load;
    assign st_inc = push & is_store;

    assign v_valid_o      = ~empty;
    assign vector_instr_o = empty ? '0 : instr_mem_q[rd_idx];
    assign rs1_o          = empty ? '0 : rs1_mem_q[rd_idx];
    assign rs2_o          = empty ? '0 : rs2_mem_q[rd_idx];

    assign all_v_loads_executed_o  = (ld_cnt_q == '0);
    assign all_v_stores_executed_o = (st_cnt_q == '0);
    assign underflow_err_o         = err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (push ? PW'(1) : PW'(0));
        rd_ptr_d = rd_ptr_q + (pop ? PW'(1) : PW'(0));
        ld_cnt_d = ld_cnt_q;
        st_cnt_d = st_cnt_q;
        err_d    = err_q;
        case ({ld_inc, v_load_done_i})
            2'b10: ld_cnt_d = ld_cnt_q + CNT_W'(1);
            2'b01: begin
                if (ld_cnt_q == '0) err_d = 1'b1;
                else ld_cnt_d = ld_cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
        case ({st_inc, v_store_done_i})
            2'b10: st_cnt_d = st_cnt_q + CNT_W'(1);
            2'b01: begin
                if (st_cnt_q == '0) err_d = 1'b1;
                else st_cnt_d = st_cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ld_cnt_q <= ld_cnt_d;
            st_cnt_q <= st_cnt_d;
            err_q    <= err_d;
        end
    end

    // Storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_idx] <= v_instr_i;
            rs1_mem_q[wr_idx]   <= rs1_i;
            rs2_mem_q[wr_idx]   <= rs2_i;
        end
    end

endmodule

// File: tb/tb_v_instr_dispatcher.sv
// Directed bench for v_instr_dispatcher: FIFO order/backpressure,
// load/store fence counters, underflow flag and async reset.
module tb_v_instr_dispatcher;

    logic        clk;
    logic        rstn;
    logic [31:0] v_instr_i;
    logic        v_instr_valid_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        vector_stall_o;
    logic [31:0] vector_instr_o;
    logic [31:0] rs1_o;
    logic [31:0] rs2_o;
    logic        v_valid_o;
    logic        v_ready_i;
    logic        v_load_done_i;
    logic        v_store_done_i;
    logic        all_v_loads_executed_o;
    logic        all_v_stores_executed_o;
    logic        underflow_err_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] OPV   = 32'h0200_0057;
    localparam logic [31:0] LOAD  = 32'h0000_0007;
    localparam logic [31:0] STORE = 32'h0000_0027;
    localparam logic [31:0] ILL   = 32'h0000_0033;

    v_instr_dispatcher #(.FIFO_DEPTH(4), .CNT_W(4)) dut (
        .clk                     (clk),
        .rstn                    (rstn),
        .v_instr_i               (v_instr_i),
        .v_instr_valid_i         (v_instr_valid_i),
        .rs1_i                   (rs1_i),
        .rs2_i                   (rs2_i),
        .vector_stall_o          (vector_stall_o),
        .vector_instr_o          (vector_instr_o),
        .rs1_o                   (rs1_o),
        .rs2_o                   (rs2_o),
        .v_valid_o               (v_valid_o),
        .v_ready_i               (v_ready_i),
        .v_load_done_i           (v_load_done_i),
        .v_store_done_i          (v_store_done_i),
        .all_v_loads_executed_o  (all_v_loads_executed_o),
        .all_v_stores_executed_o (all_v_stores_executed_o),
        .underflow_err_o         (underflow_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] opv_n(input int k);
        return {25'(k), 7'b1010111};
    endfunction

    initial begin
        rstn = 1'b0;
        v_instr_i = '0;
        v_instr_valid_i = 1'b0;
        rs1_i = '0;
        rs2_i = '0;
        v_ready_i = 1'b0;
        v_load_done_i = 1'b0;
        v_store_done_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(v_valid_o), 0);
        chk("rst_instr", vector_instr_o, 0);
        chk("rst_rs1", rs1_o, 0);
        chk("rst_stall", 32'(vector_stall_o), 0);
        chk("rst_all_ld", 32'(all_v_loads_executed_o), 1);
        chk("rst_all_st", 32'(all_v_stores_executed_o), 1);
        chk("rst_err", 32'(underflow_err_o), 0);
        rstn = 1'b1;

        // Single OP-V push, FWFT latency 1, then pop
        @(negedge clk);
        v_instr_i = OPV; rs1_i = 32'h11; rs2_i = 32'h22;
        v_instr_valid_i = 1'b1;
        #1 chk("opv_stall", 32'(vector_stall_o), 0);
        @(negedge clk);
        v_instr_valid_i = 1'b0;
        chk("opv_valid", 32'(v_valid_o), 1);
        chk("opv_instr", vector_instr_o, OPV);
        chk("opv_rs1", rs1_o, 32'h11);
        chk("opv_rs2", rs2_o, 32'h22);
        v_ready_i = 1'b1;
        @(negedge clk);
        chk("opv_popped", 32'(v_valid_o), 0);
        v_ready_i = 1'b0;

        // Five back-to-back pushes into a depth-4 FIFO
        for (int i = 0; i < 5; i++) begin
            v_instr_i = opv_n(i + 1);
            rs1_i = 32'(i + 1);
            rs2_i = 32'(100 + i);
            v_instr_valid_i = 1'b1;
            #1 chk($sformatf("fill_stall%0d", i), 32'(vector_stall_o),
                   (i == 4) ? 1 : 0);
            @(negedge clk);
        end
        v_ready_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            if (k == 3) v_instr_valid_i = 1'b0;
            #1;
            chk($sformatf("drain_valid%0d", k), 32'(v_valid_o), 1);
            chk($sformatf("drain_instr%0d", k), vector_instr_o, opv_n(k));
            chk($sformatf("drain_rs1_%0d", k), rs1_o, 32'(k));
            if (k == 1) chk("drain_full_stall", 32'(vector_stall_o), 1);
            if (k == 2) chk("drain_free_stall", 32'(vector_stall_o), 0);
            @(negedge clk);
        end
        chk("drain_empty", 32'(v_valid_o), 0);

        // Two loads then two completions
        v_instr_i = LOAD; v_instr_valid_i = 1'b1;
        @(negedge clk);
        chk("ld1_all_ld", 32'(all_v_loads_executed_o), 0);
        chk("ld1_all_st", 32'(all_v_stores_executed_o), 1);
        @(negedge clk);
        v_instr_valid_i = 1'b0;
        v_load_done_i = 1'b1;
        chk("ld2_all_ld", 32'(all_v_loads_executed_o), 0);
        @(negedge clk);
        chk("ld_done1_all_ld", 32'(all_v_loads_executed_o), 0);
        @(negedge clk);
        v_load_done_i = 1'b0;
        chk("ld_done2_all_ld", 32'(all_v_loads_executed_o), 1);
        chk("ld_done2_all_st", 32'(all_v_stores_executed_o), 1);
        chk("ld_done2_err", 32'(underflow_err_o), 0);

        // Stores: same-cycle push+done, then fill counter to 15
        v_instr_i = STORE; v_instr_valid_i = 1'b1;
        @(negedge clk);
        v_store_done_i = 1'b1;
        @(negedge clk);
        v_store_done_i = 1'b0;
        chk("st_same_err", 32'(underflow_err_o), 0);
        chk("st_same_all_st", 32'(all_v_stores_executed_o), 0);
        for (int i = 0; i < 14; i++) begin
            #1 chk($sformatf("st_push_stall%0d", i), 32'(vector_stall_o), 0);
            @(negedge clk);
        end
        #1 chk("st_max_stall", 32'(vector_stall_o), 1);
        v_instr_i = OPV;
        #1 chk("st_max_opv_stall", 32'(vector_stall_o), 0);
        v_instr_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        v_ready_i = 1'b0;
        chk("st_drained", 32'(v_valid_o), 0);
        chk("st_all_st", 32'(all_v_stores_executed_o), 0);

        // Underflow on loads, then illegal opcode drop
        v_load_done_i = 1'b1;
        @(negedge clk);
        v_load_done_i = 1'b0;
        chk("uf_err", 32'(underflow_err_o), 1);
        chk("uf_all_ld", 32'(all_v_loads_executed_o), 1);
        @(negedge clk);
        chk("uf_err_sticky", 32'(underflow_err_o), 1);
        v_instr_i = ILL; v_instr_valid_i = 1'b1;
        #1 chk("ill_stall", 32'(vector_stall_o), 0);
        @(negedge clk);
        v_instr_valid_i = 1'b0;
        chk("ill_no_entry", 32'(v_valid_o), 0);
        chk("ill_all_ld", 32'(all_v_loads_executed_o), 1);

        // Three entries queued (2 loads), then async reset mid-cycle
        v_instr_i = LOAD; v_instr_valid_i = 1'b1;
        repeat (2) @(negedge clk);
        v_instr_i = OPV;
        @(negedge clk);
        v_instr_valid_i = 1'b0;
        chk("pre_rst_valid", 32'(v_valid_o), 1);
        chk("pre_rst_all_ld", 32'(all_v_loads_executed_o), 0);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_valid", 32'(v_valid_o), 0);
        chk("arst_all_ld", 32'(all_v_loads_executed_o), 1);
        chk("arst_all_st", 32'(all_v_stores_executed_o), 1);
        chk("arst_err", 32'(underflow_err_o), 0);
        chk("arst_instr", vector_instr_o, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(v_valid_o), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/v_instr_dispatcher.md
Name: v_instr_dispatcher

Overview:
- Decoupling and scheduling stage between `scalar_core` (vector-instruction side) and `vector_core` (`vector_instr_i`/`rs1_i`/`rs2_i`).
- Buffers vector instructions with their scalar operands in a FIFO and releases them to the vector core under a valid/ready handshake.
- Counts outstanding vector loads and stores so the scalar core can fence on `all_v_loads_executed`/`all_v_stores_executed`.
- Generates the scalar-side stall on backpressure.

Parameters:
- FIFO_DEPTH, 4, entries in the instruction FIFO; power of two, ≥2.
- CNT_W, 4, width of each outstanding load/store counter; max count 2^CNT_W−1.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- v_instr_i  in  32  vector instruction from scalar core
- v_instr_valid_i  in  1  v_instr_i/rs1_i/rs2_i valid this cycle
- rs1_i  in  32  scalar rs1 value paired with instruction
- rs2_i  in  32  scalar rs2 value paired with instruction
- vector_stall_o  out  1  scalar core must hold current vector instruction
- vector_instr_o  out  32  head-entry instruction to vector core
- rs1_o  out  32  head-entry rs1
- rs2_o  out  32  head-entry rs2
- v_valid_o  out  1  head entry valid
- v_ready_i  in  1  vector core accepts head entry
- v_load_done_i  in  1  one-cycle pulse, one vector load completed
- v_store_done_i  in  1  one-cycle pulse, one vector store completed
- all_v_loads_executed_o  out  1  outstanding-load count == 0
- all_v_stores_executed_o  out  1  outstanding-store count == 0
- underflow_err_o  out  1  sticky: done pulse received with count 0

Behaviour:
- Reset (async, rstn=0): FIFO pointers 0, both counters 0, underflow_err_o=0.
  - Resulting outputs: v_valid_o=0; vector_instr_o/rs1_o/rs2_o=0; vector_stall_o=0; all_v_*_executed_o=1.
  - Reset mid-operation discards all queued entries and counts.
- Classification on opcode v_instr_i[6:0]:
  - 7'b0000111 = LOAD
  - 7'b0100111 = STORE
  - 7'b1010111 = OP-V
  - Any other opcode = ILLEGAL.
- vector_stall_o (combinational) = v_instr_valid_i & (full | (LOAD & ld_cnt==max) | (STORE & st_cnt==max)).
- Push: v_instr_valid_i & !vector_stall_o & !ILLEGAL. Writes {instr,rs1,rs2} at wr_ptr.
  - ILLEGAL is silently dropped: no push, no stall.
- full is evaluated on registered state. A push is blocked while full even if a pop happens the same cycle; there is no bypass.
- FIFO is first-word-fall-through:
  - v_valid_o = !empty.
  - Outputs drive the head entry; they are 0 when empty.
  - A push into an empty FIFO is visible at the output the next cycle (latency 1).
- Pop: v_valid_o & v_ready_i. Head advances the next cycle. Simultaneous push and pop when not full keeps occupancy.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - empty = pointers equal.
  - full = indices equal and MSBs differ.
- ld_cnt: +1 on push of LOAD, −1 on v_load_done_i.
  - Both in the same cycle: count unchanged.
  - Done with count 0 and no same-cycle increment: count stays 0 and underflow_err_o is set (sticky until reset).
- st_cnt: identical rules with STORE and v_store_done_i.
- Counters increment at enqueue, not issue, so fence status covers queued memory ops.
- all_v_loads_executed_o = (ld_cnt==0); all_v_stores_executed_o = (st_cnt==0). Both registered-derived, no input paths.
- Counter overflow cannot occur, because vector_stall_o blocks the push at max.

Test Plan:
- Reset, then push OP-V 0x0200_0057 with rs1=0x11, rs2=0x22, v_ready_i=0.
  - Next cycle: v_valid_o=1, vector_instr_o=0x0200_0057, rs1_o=0x11, rs2_o=0x22.
  - With v_ready_i=1: v_valid_o=0 one cycle later.
- v_ready_i=0, push 5 valid OP-V instructions back-to-back (FIFO_DEPTH=4).
  - Fifth cycle: vector_stall_o=1.
  - Raising v_ready_i drains entries in order 1..4, then accepts the fifth.
- Push 2 LOADs (opcode 0000111).
  - all_v_loads_executed_o=0 after first push, ld_cnt=2.
  - Two v_load_done_i pulses → all_v_loads_executed_o=1; stores flag stays 1 throughout.
- st_cnt=1, same-cycle STORE push and v_store_done_i → st_cnt stays 1, no error. Then push 14 more STOREs with v_ready_i=1.
  - At st_cnt=15, further STORE push: vector_stall_o=1.
  - OP-V push in the same state: not stalled.
- v_load_done_i with ld_cnt=0 → underflow_err_o=1 and remains 1; ld_cnt stays 0.
  - Push of opcode 0x33 → no entry, vector_stall_o=0.
- FIFO holding 3 entries and ld_cnt=2, assert rstn=0 asynchronously mid-cycle → immediately v_valid_o=0, all_v_loads_executed_o=1, underflow_err_o=0.
